// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one requester at a time a burst of up
// to MAX_BURST beats into a shared FIFO, with zero-latency data forwarding.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          write,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic                  state;
  logic [IDW-1:0]        owner;
  logic [IDW-1:0]        last;
  logic [BW-1:0]         beat_cnt;

  logic                  sel_found;
  logic [IDW-1:0]        sel_idx;
  logic [IDW-1:0]        probe;
  int                    idx;
  logic                  in_grant;
  logic                  owner_valid;
  logic                  accept;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    probe     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last) + k) % NUM_REQ;
      probe = IDW'(idx);
      if (!sel_found && req_valid[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  assign in_grant    = (state == ST_GRANT);
  assign owner_valid = req_valid[owner];
  assign accept      = in_grant && owner_valid && !fifo_full;
  assign burst_end   = (beat_cnt == BW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (in_grant && !fifo_full) begin
      req_ready[owner] = 1'b1;
    end
  end

  assign write     = accept;
  assign data_in   = accept ? words[owner] : '0;
  assign grant_vld = in_grant;
  assign grant_id  = in_grant ? owner : '0;

  // A stalled owner (full FIFO, still valid) keeps its grant and beat count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last     <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state    <= ST_GRANT;
            owner    <= sel_idx;
            last     <= sel_idx;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (!owner_valid) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end else if (accept) begin
            if (burst_end) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter: one task per scenario, each comparing
// the packed output vector against hand-derived expectations cycle by cycle.
module tb_fifo_wr_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic [DW-1:0]     data_in;
  logic              write;
  logic              grant_vld;
  logic [IDW-1:0]    grant_id;

  int checks = 0;
  int passed = 0;

  logic [15:0] obs;
  assign obs = {grant_vld, grant_id, write, data_in, req_ready};

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .data_in   (data_in),
    .write     (write),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] word(int i);
    return 8'hA0 + 8'(i * 17);
  endfunction

  function automatic logic [15:0] exp_obs(logic gv, int gid, logic wr, logic [7:0] d, logic [3:0] rdy);
    return {gv, 2'(gid), wr, d, rdy};
  endfunction

  function automatic logic [15:0] exp_idle();
    return 16'h0000;
  endfunction

  function automatic logic [15:0] exp_beat(int id);
    return exp_obs(1'b1, id, 1'b1, word(id), 4'(1 << id));
  endfunction

  function automatic logic [15:0] exp_stall(int id);
    return exp_obs(1'b1, id, 1'b0, 8'h00, 4'h0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL reset_async: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL reset_held: got %h expected %h", obs, exp_idle());
    else passed++;
  endtask

  task automatic test_single();
    logic [15:0] e;
    apply_reset();
    req_valid = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      #1;
      e = (c == 1 || c == 6) ? exp_idle() : exp_beat(0);
      checks++;
      if (obs !== e) $display("[TB] FAIL single cycle %0d: got %h expected %h", c, obs, e);
      else passed++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      checks++;
      if (obs !== exp_idle()) $display("[TB] FAIL rr_gap %0d: got %h expected %h", g, obs, exp_idle());
      else passed++;
      tick();
      for (int b = 0; b < ((g == 4) ? 1 : MB); b++) begin
        #1;
        checks++;
        if (obs !== exp_beat(g % NR))
          $display("[TB] FAIL rr_grant %0d beat %0d: got %h expected %h", g, b, obs, exp_beat(g % NR));
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL stall_idle: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++;
      if (obs !== exp_beat(1)) $display("[TB] FAIL stall_pre beat %0d: got %h expected %h", b, obs, exp_beat(1));
      else passed++;
      tick();
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (obs !== exp_stall(1)) $display("[TB] FAIL stall_hold %0d: got %h expected %h", s, obs, exp_stall(1));
      else passed++;
      tick();
    end
    fifo_full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      #1;
      checks++;
      if (obs !== exp_beat(1)) $display("[TB] FAIL stall_post beat %0d: got %h expected %h", b, obs, exp_beat(1));
      else passed++;
      tick();
    end
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL stall_end: got %h expected %h", obs, exp_idle());
    else passed++;
  endtask

  task automatic test_release();
    int writes2;
    logic [15:0] e;
    writes2 = 0;
    apply_reset();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL rel_idle: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    #1;
    if (write && grant_id == 2'd2) writes2++;
    checks++;
    if (obs !== exp_beat(2)) $display("[TB] FAIL rel_beat: got %h expected %h", obs, exp_beat(2));
    else passed++;
    tick();
    req_valid = 4'b1000;
    #1;
    if (write && grant_id == 2'd2) writes2++;
    e = exp_obs(1'b1, 2, 1'b0, 8'h00, 4'b0100);
    checks++;
    if (obs !== e) $display("[TB] FAIL rel_drop: got %h expected %h", obs, e);
    else passed++;
    tick();
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL rel_gap: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    #1;
    checks++;
    if (obs !== exp_beat(3)) $display("[TB] FAIL rel_next: got %h expected %h", obs, exp_beat(3));
    else passed++;
    checks++;
    if (writes2 !== 1) $display("[TB] FAIL rel_count: got %0d expected 1", writes2);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid = 4'b1000;
    #1;
    tick();
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++;
      if (obs !== exp_beat(3)) $display("[TB] FAIL midrst_beat %0d: got %h expected %h", b, obs, exp_beat(3));
      else passed++;
      if (b < 2) tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL midrst_async: got %h expected %h", obs, exp_idle());
    else passed++;
    req_valid = 4'b1010;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL midrst_release: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    for (int b = 0; b < MB; b++) begin
      #1;
      checks++;
      if (obs !== exp_beat(1)) $display("[TB] FAIL midrst_first beat %0d: got %h expected %h", b, obs, exp_beat(1));
      else passed++;
      tick();
    end
    #1;
    tick();
    #1;
    checks++;
    if (obs !== exp_beat(3)) $display("[TB] FAIL midrst_second: got %h expected %h", obs, exp_beat(3));
    else passed++;
  endtask

  task automatic test_full_at_grant();
    apply_reset();
    fifo_full = 1'b1;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL full_idle: got %h expected %h", obs, exp_idle());
    else passed++;
    tick();
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++;
      if (obs !== exp_stall(0)) $display("[TB] FAIL full_wait %0d: got %h expected %h", s, obs, exp_stall(0));
      else passed++;
      tick();
    end
    fifo_full = 1'b0;
    for (int b = 0; b < MB; b++) begin
      #1;
      checks++;
      if (obs !== exp_beat(0)) $display("[TB] FAIL full_beat %0d: got %h expected %h", b, obs, exp_beat(0));
      else passed++;
      tick();
    end
    #1;
    checks++;
    if (obs !== exp_idle()) $display("[TB] FAIL full_end: got %h expected %h", obs, exp_idle());
    else passed++;
  endtask

  initial begin
    req_data  = {word(3), word(2), word(1), word(0)};
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_release();
    test_reset_mid_burst();
    test_full_at_grant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
